// File: rtl/cophee_pkg.sv
// Purpose : shared types and helpers for the R^2 mod m precompute block.
// Latency : n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, MSIZE_W width of the bit-length input,
//           sat_size() clamps a requested bit length to the datapath width.
package cophee_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int MSIZE_W = 12;

    // Clamp a modulus bit length to the widest length the datapath supports.
    function automatic logic [MSIZE_W-1:0] sat_size(
        input logic [MSIZE_W-1:0] k,
        input logic [MSIZE_W-1:0] kmax
    );
        return (k > kmax) ? kmax : k;
    endfunction

endpackage

// File: rtl/mod_double_step.sv
// Purpose : one modular doubling r_out = 2*r_in mod m, assuming r_in < m.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports   : r_in  - accumulator in  (NBITS)
//           m     - modulus         (NBITS)
//           r_out - accumulator out (NBITS)
module mod_double_step #(
    parameter int NBITS = 256
) (
    input  logic [NBITS-1:0] r_in,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] r_out
);

    logic [NBITS-1:0] shl;
    logic             ge;

    assign shl = {r_in[NBITS-2:0], 1'b0};
    // The compare needs the carried-out bit of 2*r_in, so it is done at NBITS+1.
    assign ge  = {r_in, 1'b0} >= {1'b0, m};
    // When ge holds, 2*r_in - m < m fits in NBITS bits, so the difference
    // taken modulo 2^NBITS is exact even though the carry bit is dropped.
    assign r_out = ge ? (shl - m) : shl;

endmodule

// File: rtl/r2_mod_precompute.sv
// Purpose : computes R^2 mod m (R = 2^k) by repeated modular doubling of 1.
// Latency : done_irq_p after 2*k_sat+1 edges (k_sat+1 with R2MOD_RADIX4_EN).
// Backpressure: none; enable_p is accepted only in IDLE and ignored otherwise.
// Ports   : clk, rst (sync, active high), enable_p (start pulse), m (modulus),
//           m_size (bit length k), y (result), busy, done_irq_p (done pulse).
// Config  : `define R2MOD_RADIX4_EN to retire two doubling steps per cycle.
module r2_mod_precompute
    import cophee_pkg::*;
#(
    parameter int NBITS = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_p,
    input  logic [NBITS-1:0]   m,
    input  logic [MSIZE_W-1:0] m_size,
    output logic [NBITS-1:0]   y,
    output logic               busy,
    output logic               done_irq_p
);

    localparam logic [MSIZE_W-1:0] KMAX  = MSIZE_W'(NBITS);
    localparam int                 CNT_W = MSIZE_W + 1;

    state_t             state;
    logic [NBITS-1:0]   m_q;
    logic [NBITS-1:0]   r;
    logic [NBITS-1:0]   r_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_init;
    logic [MSIZE_W-1:0] k_sat;
    logic               m_lt2;
    logic               m_in_lt2;

    assign k_sat    = sat_size(m_size, KMAX);
    assign m_lt2    = (m_q[NBITS-1:1] == '0);
    assign m_in_lt2 = (m[NBITS-1:1] == '0);

`ifdef R2MOD_RADIX4_EN
    logic [NBITS-1:0] r_mid;

    mod_double_step #(.NBITS(NBITS)) u_step0 (
        .r_in  (r),
        .m     (m_q),
        .r_out (r_mid)
    );

    mod_double_step #(.NBITS(NBITS)) u_step1 (
        .r_in  (r_mid),
        .m     (m_q),
        .r_out (r_next)
    );

    // 2*k doublings at two per cycle.
    assign cnt_init = {1'b0, k_sat};
`else
    mod_double_step #(.NBITS(NBITS)) u_step0 (
        .r_in  (r),
        .m     (m_q),
        .r_out (r_next)
    );

    // 2*k doublings at one per cycle.
    assign cnt_init = {k_sat, 1'b0};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            y          <= '0;
            busy       <= 1'b0;
            done_irq_p <= 1'b0;
            r          <= '0;
            cnt        <= '0;
            m_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_irq_p <= 1'b0;
                    if (enable_p) begin
                        m_q  <= m;
                        r    <= NBITS'(1);
                        cnt  <= cnt_init;
                        busy <= 1'b1;
                        if (cnt_init == '0) begin
                            // k = 0: R^2 = 1, no iteration needed. m_q is not
                            // loaded yet, so the degenerate-modulus test uses m.
                            state      <= DONE;
                            done_irq_p <= 1'b1;
                            y          <= m_in_lt2 ? '0 : NBITS'(1);
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r   <= r_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        // Publish the final step directly so y and done_irq_p
                        // rise together on entry to DONE.
                        state      <= DONE;
                        done_irq_p <= 1'b1;
                        y          <= m_lt2 ? '0 : r_next;
                    end
                end
                DONE: begin
                    done_irq_p <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r2_mod_precompute.sv
module tb_r2_mod_precompute;
    import cophee_pkg::*;

    localparam int NBITS = 256;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable_p;
    logic [NBITS-1:0]   m;
    logic [MSIZE_W-1:0] m_size;
    logic [NBITS-1:0]   y;
    logic               busy;
    logic               done_irq_p;

    int n_vec = 0;
    int n_err = 0;

    r2_mod_precompute #(.NBITS(NBITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_p   (enable_p),
        .m          (m),
        .m_size     (m_size),
        .y          (y),
        .busy       (busy),
        .done_irq_p (done_irq_p)
    );

    always #5 clk = ~clk;

    function automatic int lat(input int k);
`ifdef R2MOD_RADIX4_EN
        return k + 1;
`else
        return 2 * k + 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [NBITS-1:0] obs, input logic [NBITS-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse a start, scramble inputs after the sampling edge, then wait
    // (bounded) for done. edges counts rising edges from the sampling edge.
    task automatic run(input logic [NBITS-1:0] mv, input logic [MSIZE_W-1:0] kv,
                       output int edges, output logic busy_ok);
        m        = mv;
        m_size   = kv;
        enable_p = 1'b1;
        @(posedge clk); #1;
        enable_p = 1'b0;
        m        = ~mv;
        m_size   = 12'd5;
        edges    = 1;
        busy_ok  = busy;
        while (done_irq_p !== 1'b1 && edges < 2000) begin
            @(posedge clk); #1;
            edges++;
            busy_ok = busy_ok & busy;
        end
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_width"}, {255'b0, done_irq_p}, 256'd0);
        chk({tag, "_busy_drop"}, {255'b0, busy}, 256'd0);
    endtask

    initial begin
        int                 e;
        logic               bok;
        logic [NBITS-1:0]   rm;
        logic [519:0]       pw;
        logic [519:0]       rem;
        int                 dones;
        int                 done_at;

        rst      = 1'b1;
        enable_p = 1'b0;
        m        = '0;
        m_size   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", y, 256'd0);
        chk("rst_busy", {255'b0, busy}, 256'd0);
        chk("rst_done", {255'b0, done_irq_p}, 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 2^8 mod 13 = 9
        run(256'd13, 12'd4, e, bok);
        chk("m13k4_lat", 256'(e), 256'(lat(4)));
        chk("m13k4_y", y, 256'd9);
        chk("m13k4_busy", {255'b0, bok}, 256'd1);
        idle_check("m13k4");
        repeat (3) @(posedge clk);
        #1;
        chk("m13k4_y_hold", y, 256'd9);

        // 2^16 mod 241 = 225
        run(256'd241, 12'd8, e, bok);
        chk("m241k8_lat", 256'(e), 256'(lat(8)));
        chk("m241k8_y", y, 256'd225);
        idle_check("m241k8");

        // k = 0: R^2 = 1
        run(256'd13, 12'd0, e, bok);
        chk("k0_lat", 256'(e), 256'(lat(0)));
        chk("k0_y", y, 256'd1);
        chk("k0_busy", {255'b0, bok}, 256'd1);
        idle_check("k0");

        // m = 0 is degenerate: full run, forced zero
        run(256'd0, 12'd4, e, bok);
        chk("m0_lat", 256'(e), 256'(lat(4)));
        chk("m0_y", y, 256'd0);
        idle_check("m0");

        // m_size above NBITS saturates to 256: 2^512 mod 13 = 9
        run(256'd13, 12'd300, e, bok);
        chk("sat_lat", 256'(e), 256'(lat(256)));
        chk("sat_y", y, 256'd9);
        idle_check("sat");

        // Random odd full-width moduli against a wide-division reference.
        for (int t = 0; t < 3; t++) begin
            for (int w = 0; w < 8; w++) rm[w*32 +: 32] = $urandom;
            rm[0]   = 1'b1;
            rm[255] = 1'b1;
            pw  = 520'd1 << 512;
            rem = pw % {264'd0, rm};
            run(rm, 12'd256, e, bok);
            chk("rnd_lat", 256'(e), 256'(lat(256)));
            chk("rnd_y", y, rem[255:0]);
            idle_check("rnd");
        end

        // Re-pulse enable during the run and in the done cycle: both ignored.
        m        = 256'd13;
        m_size   = 12'd4;
        enable_p = 1'b1;
        dones    = 0;
        done_at  = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done_irq_p === 1'b1) begin
                dones++;
                if (done_at == 0) done_at = n;
            end
            enable_p = (n == 3 || n == lat(4)) ? 1'b1 : 1'b0;
        end
        chk("repulse_count", 256'(dones), 256'd1);
        chk("repulse_lat", 256'(done_at), 256'(lat(4)));
        chk("repulse_y", y, 256'd9);
        chk("repulse_idle", {255'b0, busy}, 256'd0);

        // Reset mid-run aborts: no done, outputs cleared on the next edge.
        m        = 256'd241;
        m_size   = 12'd8;
        enable_p = 1'b1;
        @(posedge clk); #1;
        enable_p = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_y", y, 256'd0);
        chk("abort_busy", {255'b0, busy}, 256'd0);
        rst   = 1'b0;
        dones = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
            if (done_irq_p === 1'b1) dones++;
        end
        chk("abort_no_done", 256'(dones), 256'd0);

        run(256'd13, 12'd4, e, bok);
        chk("after_abort_lat", 256'(e), 256'(lat(4)));
        chk("after_abort_y", y, 256'd9);
        idle_check("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/r2_mod_precompute.md
Name: r2_mod_precompute

Overview:
- Computes the Montgomery constant R^2 mod m, where R = 2^m_size, by iterated modular doubling.
- Sits upstream of the to-Montgomery conversion and exponentiation stages; its y feeds their b operand.
- Runs once per new modulus. Uses the same enable_p / done_irq_p pulse handshake as the Montgomery multiplier family.

Parameters:
- NBITS, 256, operand/modulus width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable_p  input  1  one-cycle start pulse; sampled only when idle.
- m  input  NBITS  modulus; odd, >1 for a meaningful result.
- m_size  input  12  modulus bit length k; R = 2^k.
- y  output  NBITS  result R^2 mod m; valid when done_irq_p is high and held until the next accepted start.
- busy  output  1  high from the cycle after start is accepted until done_irq_p is high, inclusive.
- done_irq_p  output  1  one-cycle completion pulse.

Behaviour:
- Reset, synchronous and active-high: state=IDLE, y=0, busy=0, done_irq_p=0, internal accumulator r=0, counter=0.
- Reset mid-operation aborts the run: no done_irq_p, and the outputs take their reset values on the next edge.
- States:
  - IDLE: on enable_p=1, latch m into m_q and latch m_size saturated to NBITS; set r=1, cnt=2*k_sat, busy=1. Go to RUN, or to DONE if cnt==0.
  - RUN: each cycle perform one step and decrement cnt; after the step where cnt reaches 0, go to DONE.
  - DONE: y<=r, or 0 if m_q<2. done_irq_p=1 for exactly this cycle, busy=1. Next state is IDLE.
- One step is r' = 2r; if r' >= m_q then r' = r' - m_q.
  - Compare and subtract are done at NBITS+1 bits.
  - Invariant: r < m_q, so r' < 2*m_q fits in NBITS+1 bits and the result fits in NBITS.
- Latency: done_irq_p is high in the cycle after the (2*k_sat+1)-th rising edge counted from the edge that samples enable_p; for k=0 that is 1 edge.
- done_irq_p and busy are registered outputs.
- enable_p is ignored while not IDLE, including in the DONE cycle.
- m_q<2: the iteration still runs for the full count and the result is forced to 0. The block never hangs.
- Even m: the loop runs normally and y = 2^(2k) mod m. Even m is not usable downstream; rejecting it is the caller's responsibility.
- m_size > NBITS: saturates to NBITS, so cnt = 2*NBITS.
- Inputs m and m_size may change after the start edge without effect.

Optional Feature:
- Macro: R2MOD_RADIX4_EN.
- When defined:
  - RUN performs two chained doubling steps per cycle; cnt is loaded with k_sat and decrements by 1.
  - Latency becomes k_sat+1 edges.
  - Results are identical to the baseline.
- When undefined: one step per cycle, as above.
- Port list is identical in both builds.

Decomposition:
- Shared package (cophee_pkg):
  - state enum typedef: IDLE, RUN, DONE.
  - MSIZE_W=12 constant.
  - a function returning the saturated bit length.
- Sub-module mod_double_step (NBITS param): purely combinational, r_in and m in, r_out out.
  - Instantiated once, or twice chained under R2MOD_RADIX4_EN.

Test Plan:
- NBITS=256, m=13, m_size=4, pulse enable_p:
  - done_irq_p high 9 edges later.
  - y=9 (256 mod 13).
  - busy high throughout.
  - done pulse lasts exactly 1 cycle.
- m=241, m_size=8:
  - y=225 (65536 mod 241) after 17 edges.
- m=13, m_size=0:
  - y=1 after 1 edge.
- Random odd 256-bit m with m_size=256:
  - y equals the reference model 2^512 mod m after 513 edges.
- enable_p re-pulsed at cycles 3 and 9 of a 13/4 run:
  - both pulses ignored; exactly one done_irq_p; y=9.
- rst asserted at cycle 4 of a run:
  - next edge y=0, busy=0; no done_irq_p.
  - a following fresh start with 13/4 gives y=9.
- m=0, m_size=4:
  - y=0; done_irq_p after 9 edges.
- R2MOD_RADIX4_EN build, m=13, m_size=4:
  - y=9 after 5 edges.
